// File: rtl/sf_parser_mc.sv
// Layer III scalefactor (part2) parser: decodes every granule/channel part of a frame, with scfsi reuse.
// Define SF_LEN_CHECK_EN to add the err output (part2 length exceeding part2_3_length).
module sf_parser_mc #(
  parameter int unsigned NCH = 2,
  parameter int unsigned NGR = 2,
  parameter int unsigned NP  = NGR * NCH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si_valid,
  input  logic [NP*4-1:0]  scalefac_compress_in,
  input  logic [NP-1:0]    window_switching_flag_in,
  input  logic [NP*2-1:0]  block_type_in,
  input  logic [NP-1:0]    mixed_block_flag_in,
  input  logic [NCH*4-1:0] scfsi_in,
  input  logic [NP*12-1:0] part2_3_length_in,
  input  logic             axiid,
  input  logic             axiiv,
  output logic             axiir,
  output logic [83:0]      scalefac_l,
  output logic [143:0]     scalefac_s,
  output logic [7:0]       part2_bits,
  output logic             gr_out,
  output logic             ch_out,
  output logic             axiov,
  output logic             busy,
`ifdef SF_LEN_CHECK_EN
  output logic             err,
`endif
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StSetup, StLong, StShort, StEmit} state_e;

  function automatic logic [2:0] slen1_f(input logic [3:0] c);
    case (c)
      4'd0, 4'd1, 4'd2, 4'd3:   slen1_f = 3'd0;
      4'd4:                     slen1_f = 3'd3;
      4'd5, 4'd6, 4'd7:         slen1_f = 3'd1;
      4'd8, 4'd9, 4'd10:        slen1_f = 3'd2;
      4'd11, 4'd12, 4'd13:      slen1_f = 3'd3;
      default:                  slen1_f = 3'd4;
    endcase
  endfunction

  function automatic logic [2:0] slen2_f(input logic [3:0] c);
    case (c)
      4'd0, 4'd4:                         slen2_f = 3'd0;
      4'd1, 4'd5, 4'd8, 4'd11:            slen2_f = 3'd1;
      4'd2, 4'd6, 4'd9, 4'd12, 4'd14:     slen2_f = 3'd2;
      default:                            slen2_f = 3'd3;
    endcase
  endfunction

  function automatic logic [1:0] grp_f(input int unsigned sfb);
    if (sfb < 6)       grp_f = 2'd0;
    else if (sfb < 11) grp_f = 2'd1;
    else if (sfb < 16) grp_f = 2'd2;
    else               grp_f = 2'd3;
  endfunction

  state_e         state_q, state_d;
  logic [2:0]     k_q, k_d, cnt_q, cnt_d;
  logic [4:0]     sfb_q, sfb_d;
  logic [1:0]     win_q, win_d;
  logic [3:0]     acc_q, acc_d, acc_next;
  logic [7:0]     p2b_q, p2b_d;
  logic [83:0]    wl_q, wl_d;
  logic [143:0]   ws_q, ws_d;
  logic           mixed_q, mixed_d, short_q, short_d;
  logic [NP*4-1:0]  sc_q;
  logic [NP-1:0]    wsf_q, mbf_q;
  logic [NP*2-1:0]  bt_q;
  logic [NCH*4-1:0] scfsi_q;
  logic [83:0]    store_q [NCH];
  logic [83:0]    l_q;
  logic [143:0]   s_q;
  logic [7:0]     bits_q;
  logic           gr_q, ch_q, axiov_q, busy_q, done_q, last_q, done_set;
  logic           accept, emit, adv;

  logic [3:0] c_cur;
  logic [2:0] s1, s2, slen_cur;
  logic [1:0] grp;
  logic       part_short, part_mixed, cur_gr, cur_ch, reuse;
  int         lidx, sidx;

  // Decode of the current part and field position.
  always_comb begin
    c_cur      = sc_q[int'(k_q)*4 +: 4];
    s1         = slen1_f(c_cur);
    s2         = slen2_f(c_cur);
    part_short = wsf_q[int'(k_q)] && (bt_q[int'(k_q)*2 +: 2] == 2'd2) && !mbf_q[int'(k_q)];
    part_mixed = wsf_q[int'(k_q)] && (bt_q[int'(k_q)*2 +: 2] == 2'd2) && mbf_q[int'(k_q)];
    cur_gr     = (NGR == 2) && (int'(k_q) >= int'(NCH));
    cur_ch     = (NCH == 2) && k_q[0];
    grp        = grp_f(int'(sfb_q));
    reuse      = (state_q == StLong) && cur_gr && !mixed_q &&
                 (sfb_q == 5'd0 || sfb_q == 5'd6 || sfb_q == 5'd11 || sfb_q == 5'd16) &&
                 scfsi_q[int'(cur_ch)*4 + int'(grp)];
    if (state_q == StLong) slen_cur = (sfb_q < 5'd11) ? s1 : s2;
    else                   slen_cur = (sfb_q < 5'd6) ? s1 : s2;
    lidx       = int'(sfb_q) * 4;
    sidx       = (int'(sfb_q) * 3 + int'(win_q)) * 4;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    sfb_d    = sfb_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    p2b_d    = p2b_q;
    wl_d     = wl_q;
    ws_d     = ws_q;
    mixed_d  = mixed_q;
    short_d  = short_q;
    axiir    = 1'b0;
    accept   = 1'b0;
    emit     = 1'b0;
    adv      = 1'b0;
    acc_next = {acc_q[2:0], axiid};
    unique case (state_q)
      StIdle: begin
        if (si_valid && !busy_q) begin
          accept  = 1'b1;
          k_d     = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        wl_d    = '0;
        ws_d    = '0;
        sfb_d   = '0;
        win_d   = '0;
        cnt_d   = '0;
        acc_d   = '0;
        p2b_d   = '0;
        short_d = part_short;
        mixed_d = part_mixed;
        state_d = part_short ? StShort : StLong;
      end
      StLong, StShort: begin
        if (reuse) begin
          for (int i = 0; i < 21; i++) begin
            if (grp_f(i) == grp) wl_d[i*4 +: 4] = store_q[cur_ch][i*4 +: 4];
          end
          case (grp)
            2'd0:    sfb_d = 5'd6;
            2'd1:    sfb_d = 5'd11;
            2'd2:    sfb_d = 5'd16;
            default: state_d = StEmit;
          endcase
        end else if (slen_cur == 3'd0) begin
          adv = 1'b1;
        end else begin
          axiir = 1'b1;
          if (axiiv) begin
            p2b_d = p2b_q + 8'd1;
            if (cnt_q == slen_cur - 3'd1) begin
              if (state_q == StLong) wl_d[lidx +: 4] = acc_next;
              else                   ws_d[sidx +: 4] = acc_next;
              cnt_d = '0;
              acc_d = '0;
              adv   = 1'b1;
            end else begin
              cnt_d = cnt_q + 3'd1;
              acc_d = acc_next;
            end
          end
        end
        if (adv) begin
          if (state_q == StLong) begin
            // Mixed blocks continue with short sfb 3 after long sfb 7.
            if (mixed_q && sfb_q == 5'd7) begin
              state_d = StShort;
              sfb_d   = 5'd3;
              win_d   = '0;
            end else if (sfb_q == 5'd20) begin
              state_d = StEmit;
            end else begin
              sfb_d = sfb_q + 5'd1;
            end
          end else if (win_q != 2'd2) begin
            win_d = win_q + 2'd1;
          end else if (sfb_q == 5'd11) begin
            state_d = StEmit;
          end else begin
            sfb_d = sfb_q + 5'd1;
            win_d = '0;
          end
        end
      end
      StEmit: begin
        emit    = 1'b1;
        k_d     = k_q + 3'd1;
        state_d = (int'(k_q) == int'(NP) - 1) ? StIdle : StSetup;
      end
      default: state_d = StIdle;
    endcase
  end

  assign done_set = axiov_q && last_q;

`ifdef SF_LEN_CHECK_EN
  logic [NP*12-1:0] len_q;
  logic             err_q;
  assign err = err_q;
`else
  logic unused_len;
  assign unused_len = ^part2_3_length_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      sfb_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      p2b_q   <= '0;
      wl_q    <= '0;
      ws_q    <= '0;
      mixed_q <= 1'b0;
      short_q <= 1'b0;
      sc_q    <= '0;
      wsf_q   <= '0;
      bt_q    <= '0;
      mbf_q   <= '0;
      scfsi_q <= '0;
      for (int i = 0; i < int'(NCH); i++) store_q[i] <= '0;
      l_q     <= '0;
      s_q     <= '0;
      bits_q  <= '0;
      gr_q    <= 1'b0;
      ch_q    <= 1'b0;
      axiov_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
`ifdef SF_LEN_CHECK_EN
      len_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      sfb_q   <= sfb_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p2b_q   <= p2b_d;
      wl_q    <= wl_d;
      ws_q    <= ws_d;
      mixed_q <= mixed_d;
      short_q <= short_d;
      axiov_q <= 1'b0;
      done_q  <= done_set;
`ifdef SF_LEN_CHECK_EN
      err_q   <= 1'b0;
`endif
      if (accept) begin
        sc_q    <= scalefac_compress_in;
        wsf_q   <= window_switching_flag_in;
        bt_q    <= block_type_in;
        mbf_q   <= mixed_block_flag_in;
        scfsi_q <= scfsi_in;
        busy_q  <= 1'b1;
`ifdef SF_LEN_CHECK_EN
        len_q   <= part2_3_length_in;
`endif
      end else if (done_set) begin
        busy_q <= 1'b0;
      end
      if (emit) begin
        axiov_q <= 1'b1;
        l_q     <= wl_q;
        s_q     <= ws_q;
        bits_q  <= p2b_q;
        gr_q    <= cur_gr;
        ch_q    <= cur_ch;
        last_q  <= (int'(k_q) == int'(NP) - 1);
        if (!mixed_q && !short_q && !cur_gr) store_q[cur_ch] <= wl_q;
`ifdef SF_LEN_CHECK_EN
        if ({4'd0, p2b_q} > len_q[int'(k_q)*12 +: 12]) begin
          err_q <= 1'b1;
          l_q   <= '0;
          s_q   <= '0;
        end
`endif
      end
    end
  end

  assign scalefac_l = l_q;
  assign scalefac_s = s_q;
  assign part2_bits = bits_q;
  assign gr_out     = gr_q;
  assign ch_out     = ch_q;
  assign axiov      = axiov_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/sf_parser_mc.md
Name: sf_parser_mc

Overview:
- Multi-granule, multi-channel MPEG-1/2 Layer III scalefactor (part2) parser.
- Decodes the scalefactors of every granule/channel part of one frame from a serial MSB-first bit stream, in the order gr0ch0, gr0ch1, gr1ch0, gr1ch1.
- Applies scfsi reuse for granule 1, so reused scalefactor groups consume no bits.
- Sits between the side-info parser and the Huffman (part3) decoder. Reports part2 bit count per part so part3 can start at the correct bit.

Parameters:
- NCH, 2, channel count (1 or 2).
- NGR, 2, granules per frame (2 = MPEG-1, 1 = MPEG-2 LSF; scfsi is ignored when NGR=1).
- NP, NGR*NCH, derived: parts per frame. Part index k = gr*NCH + ch.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- si_valid  in  1  one-cycle pulse; all *_in side info valid
- scalefac_compress_in  in  NP*4  per part, field k at [4k+3:4k]
- window_switching_flag_in  in  NP  per part
- block_type_in  in  NP*2  per part
- mixed_block_flag_in  in  NP  per part
- scfsi_in  in  NCH*4  per channel; bit g = group g
- part2_3_length_in  in  NP*12  per part; used only with the optional feature
- axiid  in  1  serial data bit
- axiiv  in  1  data valid
- axiir  out  1  ready; a bit is consumed when axiiv && axiir
- scalefac_l  out  21*4  long sfb i at [4i+3:4i]
- scalefac_s  out  12*3*4  sfb i, window w at [(3i+w)*4 +: 4]
- part2_bits  out  8  bits consumed for this part
- gr_out  out  1  granule of the emitted part
- ch_out  out  1  channel of the emitted part
- axiov  out  1  one-cycle pulse; outputs valid
- busy  out  1  high from accept to frame done
- done  out  1  one-cycle pulse after the last part

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including scalefac regs and the gr0 copy store.
- IDLE: on si_valid, latch all *_in, set k=0, busy=1, go to SETUP. si_valid while busy is ignored.
- slen from scalefac_compress (c=0..15):
  - slen1 = 0,0,0,0,3,1,1,1,2,2,2,3,3,3,4,4
  - slen2 = 0,1,2,3,0,1,2,3,1,2,3,1,2,3,2,3
- Part layout is decided in SETUP; clear the part's scalefac_l and scalefac_s to 0.
  - Short, non-mixed (window_switching_flag=1, block_type=2, mixed_block_flag=0): short sfb 0-5 with slen1, sfb 6-11 with slen2. For each sfb, windows 0,1,2.
  - Mixed (window_switching_flag=1, block_type=2, mixed_block_flag=1): long sfb 0-7 with slen1, then short sfb 3-11 with windows 0,1,2. Short sfb 3-5 use slen1; sfb 6-11 use slen2.
  - Long (otherwise): groups 0:sfb0-5, 1:sfb6-10 with slen1; groups 2:sfb11-15, 3:sfb16-20 with slen2.
  - Reuse: if gr=1 and scfsi_in[ch][g]=1, copy group g from the gr0 store for that channel; consume 0 bits.
- SHIFT: axiir=1 only while the current field has slen>0. Shift in MSB first, one bit per valid beat. axiiv=0 stalls with no state change. After slen bits, write the field and advance.
- Fields with slen=0 are written 0 and take one cycle with axiir=0. A copied group takes one cycle.
- Long parts at gr=0 also write the result into the gr0 store for that channel.
- part2_bits counts consumed bits, 8-bit, no wrap (max 126).
- EMIT: axiov=1 for one cycle. Outputs hold until the next EMIT. Then k++: go to SETUP if k<NP, else pulse done, busy=0, go to IDLE.
- Latency: SETUP 1 cycle + fields + EMIT 1 cycle per part.
- Reset asserted mid-part aborts immediately; no axiov is emitted.

Optional Feature:
- Macro: SF_LEN_CHECK_EN.
- Defined: adds output port err (1 bit, reset 0), which pulses with axiov when part2_bits > part2_3_length of that part. On error, scalefac_l and scalefac_s for that part are forced to 0. Parsing continues with the next part.
- Undefined: no err port and no comparison. part2_3_length_in is unused.

Test Plan:
- NCH=1, NGR=1, long, c=15, all-ones stream -> one axiov; scalefac_l[0..10]=15, [11..20]=7; part2_bits=74; done next cycle.
- Short non-mixed, c=13, stream of all ones -> all 36 scalefac_s entries = 7; part2_bits=108; scalefac_l all 0.
- Mixed, c=9, ones -> scalefac_l[0..7]=3; scalefac_s sfb3-5 = 3, sfb6-11 = 7; part2_bits=88.
- NCH=2, long c=15 all parts, scfsi ch0=4'b1111, ch1=4'b0000, distinct gr0 patterns:
  - gr1ch0 equals gr0ch0 with part2_bits=0.
  - gr1ch1 consumes 74 bits.
  - gr/ch tags arrive in order 00, 01, 10, 11.
- c=0 -> axiir never high; all scalefacs 0; part2_bits=0. axiiv toggling mid-field stalls without corruption. rst_n low mid-field -> all outputs 0, busy=0.
- SF_LEN_CHECK_EN defined, c=15 long, part2_3_length=50 -> err=1 with axiov, scalefacs 0. With length=74 -> err=0.
